// File: rtl/mpmc10_strip_seq.sv
// mpmc10_strip_seq -- multi-strip burst sequencer between the mpmc10 port
// arbiter and the DDR application interface.
//
// One granted request (read or write, 1..64 strips of STRIP_BYTES each) is
// latched in IDLE. Writes alternate one data beat and one command per strip.
// Reads issue commands back-to-back while counting returning strips. A
// one-cycle done pulse marks completion.
//
// Optional feature macro: MPMC10_STRIP_TIMEOUT_EN
//   defined   -> an 8-bit read-wait watchdog forces DONE with err=1
//   undefined -> RD_WAIT waits indefinitely, err is tied to 0
//
// Ports:
//   clk, rstn               clock, asynchronous active-low reset
//   req/req_we/req_adr/     granted request (level, sampled only in IDLE),
//   req_num_strips          strip count minus one
//   ack                     request latched (combinational in IDLE)
//   wstrip_next, strip_idx  write source advance pulse / current strip
//   rd_strip_valid/_idx     returning read strip and its index
//   app_en/cmd/addr/rdy     DDR command channel
//   app_wdf_wren/end/rdy    DDR write-data channel (one beat per strip)
//   app_rd_data_valid       DDR read-data return
//   busy, done, err         status; err is valid with done
//   dbg_state               current FSM state for observation
//
// Handshakes: a command transfers on a cycle where app_en & app_rdy, a write
// beat where app_wdf_wren & app_wdf_rdy. Once raised, app_en/app_wdf_wren and
// their payload hold until that transfer cycle.

module mpmc10_strip_seq #(
    parameter int AW          = 29,
    parameter int STRIP_BYTES = 16
) (
    input  logic          clk,
    input  logic          rstn,
    input  logic          req,
    input  logic          req_we,
    input  logic [AW-1:0] req_adr,
    input  logic [5:0]    req_num_strips,
    output logic          ack,
    output logic          wstrip_next,
    output logic [5:0]    strip_idx,
    output logic          rd_strip_valid,
    output logic [5:0]    rd_strip_idx,
    output logic          app_en,
    output logic [2:0]    app_cmd,
    output logic [AW-1:0] app_addr,
    input  logic          app_rdy,
    output logic          app_wdf_wren,
    output logic          app_wdf_end,
    input  logic          app_wdf_rdy,
    input  logic          app_rd_data_valid,
    output logic          busy,
    output logic          done,
    output logic          err,
    output logic [2:0]    dbg_state
);

    localparam int            SHIFT    = $clog2(STRIP_BYTES);
    localparam logic [AW-1:0] LOW_MASK = AW'(STRIP_BYTES - 1);

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        WR_DATA = 3'd1,
        WR_CMD  = 3'd2,
        RD_CMD  = 3'd3,
        RD_WAIT = 3'd4,
        DONE    = 3'd5
    } state_e;

    state_e        state_q, state_d;
    logic [AW-1:0] base_q, base_d;
    logic [5:0]    n_q, n_d;
    logic [5:0]    cmd_cnt_q, cmd_cnt_d;
    logic [5:0]    dat_cnt_q, dat_cnt_d;
    logic          err_q, err_d;

    logic rd_active;
    logic rd_hit;
    logic rd_last;

    // Read data only counts while a read is in flight; stray valids are ignored.
    assign rd_active = (state_q == RD_CMD) || (state_q == RD_WAIT);
    assign rd_hit    = rd_active && app_rd_data_valid;
    assign rd_last   = rd_hit && (dat_cnt_q == n_q);

`ifdef MPMC10_STRIP_TIMEOUT_EN
    logic [7:0] to_q, to_d;
    logic       to_expired;

    assign to_expired = (to_q == 8'hFF);

    always_comb begin
        to_d = to_q;
        if (app_rd_data_valid) begin
            to_d = 8'd0;
        end else if (state_q == RD_CMD && state_d == RD_WAIT) begin
            to_d = 8'd0;
        end else if (state_q == RD_WAIT) begin
            to_d = to_q + 8'd1;
        end
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            to_q <= 8'd0;
        end else begin
            to_q <= to_d;
        end
    end
`else
    logic to_expired;
    assign to_expired = 1'b0;
`endif

    always_comb begin
        state_d     = state_q;
        base_d      = base_q;
        n_d         = n_q;
        cmd_cnt_d   = cmd_cnt_q;
        dat_cnt_d   = dat_cnt_q;
        err_d       = err_q;
        ack         = 1'b0;
        wstrip_next = 1'b0;

        // Saturate at n: the data counter never runs past the last strip.
        if (rd_hit && (dat_cnt_q != n_q)) begin
            dat_cnt_d = dat_cnt_q + 6'd1;
        end

        unique case (state_q)
            IDLE: begin
                if (req) begin
                    ack       = 1'b1;
                    base_d    = req_adr & ~LOW_MASK;
                    n_d       = req_num_strips;
                    cmd_cnt_d = 6'd0;
                    dat_cnt_d = 6'd0;
                    err_d     = 1'b0;
                    state_d   = req_we ? WR_DATA : RD_CMD;
                end
            end
            WR_DATA: begin
                if (app_wdf_rdy) begin
                    wstrip_next = 1'b1;
                    state_d     = WR_CMD;
                end
            end
            WR_CMD: begin
                if (app_rdy) begin
                    if (cmd_cnt_q == n_q) begin
                        state_d = DONE;
                    end else begin
                        cmd_cnt_d = cmd_cnt_q + 6'd1;
                        state_d   = WR_DATA;
                    end
                end
            end
            RD_CMD: begin
                if (app_rdy) begin
                    if (cmd_cnt_q == n_q) begin
                        // Final data may land in the same cycle as the final command.
                        state_d = rd_last ? DONE : RD_WAIT;
                    end else begin
                        cmd_cnt_d = cmd_cnt_q + 6'd1;
                    end
                end
            end
            RD_WAIT: begin
                if (rd_last) begin
                    state_d = DONE;
                end else if (to_expired) begin
                    err_d   = 1'b1;
                    state_d = DONE;
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_q   <= IDLE;
            base_q    <= '0;
            n_q       <= 6'd0;
            cmd_cnt_q <= 6'd0;
            dat_cnt_q <= 6'd0;
            err_q     <= 1'b0;
        end else begin
            state_q   <= state_d;
            base_q    <= base_d;
            n_q       <= n_d;
            cmd_cnt_q <= cmd_cnt_d;
            dat_cnt_q <= dat_cnt_d;
            err_q     <= err_d;
        end
    end

    // All command-side outputs decode registered state only, so they cannot
    // move while a transfer is stalled. Address wraps modulo 2^AW.
    assign app_en         = (state_q == WR_CMD) || (state_q == RD_CMD);
    assign app_cmd        = {2'b00, (state_q == RD_CMD)};
    assign app_addr       = base_q + (AW'(cmd_cnt_q) << SHIFT);
    assign app_wdf_wren   = (state_q == WR_DATA);
    assign app_wdf_end    = (state_q == WR_DATA);
    assign strip_idx      = cmd_cnt_q;
    assign rd_strip_valid = rd_hit;
    assign rd_strip_idx   = dat_cnt_q;
    assign busy           = (state_q != IDLE);
    assign done           = (state_q == DONE);
    assign dbg_state      = state_q;

`ifdef MPMC10_STRIP_TIMEOUT_EN
    assign err = err_q;
`else
    assign err = 1'b0;
`endif

endmodule

// File: doc/mpmc10_strip_seq.md
# mpmc10_strip_seq

Multi-strip burst sequencer between the mpmc10 port arbiter and the DDR application interface. It accepts one granted request (read or write, 1–64 strips of 16 bytes), issues the per-strip commands and write-data beats with `app_rdy`/`app_wdf_rdy` handshaking, and counts returning read strips. It reports completion with a one-cycle `done` pulse. It replaces open-coded strip counting in the controller state machine with a single owner for command and data counts.

## Interface
- `AW`, default 29: DDR application address width.
- `STRIP_BYTES`, default 16: address increment per strip; must be a power of two.
- `clk` input 1: controller clock.
- `rstn` input 1: reset, asynchronous, active-low.
- `req` input 1: granted request valid; level, sampled only in IDLE.
- `req_we` input 1: 1 = write, 0 = read.
- `req_adr` input AW: start address; low log2(STRIP_BYTES) bits are forced to 0.
- `req_num_strips` input 6: strip count minus one (0 means 1 strip).
- `ack` output 1: one-cycle pulse when the request is latched.
- `wstrip_next` output 1: pulse; the write strip `strip_idx` was consumed and the source advances.
- `strip_idx` output 6: strip currently being issued.
- `rd_strip_valid` output 1: copy of `app_rd_data_valid` while in a read.
- `rd_strip_idx` output 6: index of the returning read strip.
- `app_en`, `app_cmd[2:0]`, `app_addr[AW-1:0]` outputs: DDR command (write 3'b000, read 3'b001).
- `app_rdy` input 1: command accepted when `app_en & app_rdy`.
- `app_wdf_wren`, `app_wdf_end` outputs 1: write-data beat; `end` is always equal to `wren` (one beat per strip).
- `app_wdf_rdy` input 1: write beat accepted when `wren & wdf_rdy`.
- `app_rd_data_valid` input 1: one read strip returned.
- `busy` output 1: the state is not IDLE.
- `done` output 1: one-cycle completion pulse.
- `err` output 1: read timeout flag, valid with `done`.

## Operation
- States are IDLE, WR_DATA, WR_CMD, RD_CMD, RD_WAIT, and DONE.
- **IDLE:**
  - On `req`, latch `we`, the base address, and `n=req_num_strips`.
  - Pulse `ack` and clear `cmd_cnt`, `dat_cnt`, and `err`.
  - Go to WR_DATA if `we`, otherwise to RD_CMD.
- **WR_DATA:**
  - Hold `wren=end=1` until `wdf_rdy`.
  - On acceptance, pulse `wstrip_next` and go to WR_CMD.
- **WR_CMD:**
  - Hold `app_en=1`, `cmd=000`, `addr=base+cmd_cnt*STRIP_BYTES` until `app_rdy`.
  - On acceptance, if `cmd_cnt==n` go to DONE; otherwise increment `cmd_cnt` and return to WR_DATA.
- **RD_CMD:**
  - Issue read commands back-to-back, and increment `cmd_cnt` on each acceptance.
  - On acceptance with `cmd_cnt==n`, go to RD_WAIT.
- **Read data (RD_CMD and RD_WAIT):**
  - Each `app_rd_data_valid` increments `dat_cnt`.
  - `rd_strip_idx=dat_cnt` before the increment.
- **RD_WAIT:** go to DONE on the valid where `dat_cnt==n`. If the final command and the final data arrive in the same RD_CMD cycle, go directly to DONE.
- **DONE:** pulse `done`, then go to IDLE. A `req` presented during DONE is accepted in the following IDLE cycle.
- **Counters and addressing:**
  - `strip_idx=cmd_cnt`.
  - Counters are 6 bits and never exceed `n`.
  - Address arithmetic is modulo 2^AW, so the last strip wraps at the top of the space.
- `app_rd_data_valid` outside a read is ignored and does not update `rd_strip_valid`.

## Timing
- **Reset values:** all outputs are 0, counters are 0, and the state is IDLE. Reset asserted mid-burst aborts immediately, with no `done`.
- `ack` is asserted in the same cycle `req` is sampled in IDLE. The first `app_en` or `wren` is asserted the next cycle.
- **Minimum write latency:** 2n+2 handshake cycles plus 1 cycle in DONE.
- **Minimum read command issue:** n+1 cycles at one command per cycle.
- Command outputs are registered and stable while stalled. `app_addr` and `cmd` do not change while `app_en & !app_rdy`.

## Configuration
- `MPMC10_STRIP_TIMEOUT_EN`:
  - **Defined:** an 8-bit counter clears on every `app_rd_data_valid` and on entry to RD_WAIT, and increments each RD_WAIT cycle. At 255 the block goes to DONE with `err=1`.
  - **Undefined:** RD_WAIT waits indefinitely, and `err` is tied to 0.

## Test plan
- **Single write:** write, n=0, adr=0x100, `wdf_rdy` and `app_rdy` held high → one `wren`, then one `app_en` with addr 0x100 and cmd 000. `done` pulses 3 cycles after `ack`.
- **Stalled write:** write, n=3, `app_rdy` low for 2 cycles on strip 1 → addresses 0x100/0x110/0x120/0x130 in order, addr stable during the stall, 4 `wstrip_next` pulses, and `done` exactly once.
- **Read with data during commands:** read, n=3, data valid arriving 5 cycles after each command (some overlapping RD_CMD) → `rd_strip_idx` 0,1,2,3 and `done` the cycle after the 4th valid.
- **Address wrap:** read, n=1, adr=2^AW−16 → addresses 2^AW−16 then 0.
- **Reset mid-read:** `rstn` low during RD_WAIT → all outputs 0 immediately, no `done`, and the next request runs normally.
- **Timeout (with `MPMC10_STRIP_TIMEOUT_EN`):** read, n=1, only one valid returned → `done` with `err=1` 255 cycles after the last event.
